fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage with a small prefetch queue, sitting directly upstream of the IF/ID pipeline buffer. It owns the PC, issues word fetches to the instruction memory, and queues returned instructions with their PC+4. It presents one instruction per cycle to the IF/ID buffer, holds under decode stall, and flushes on a taken-branch redirect from the EX/MEM branch logic.

## Interface
- `DEPTH`, default 4: prefetch queue entries; legal values are powers of two, ≥2.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  32  fetch address; always word-aligned.
- `imem_rdata`  in  32  instruction word; valid exactly one cycle after the cycle in which `imem_req`=1.
- `redirect`  in  1  taken branch (PCSrc).
- `redirect_pc`  in  32  branch target; bits [1:0] are ignored and treated as 0.
- `id_stall`  in  1  IF/ID buffer cannot accept this cycle.
- `if_valid`  out  1  `if_instr`/`if_pc4` hold a valid instruction.
- `if_instr`  out  32  head instruction; 32'h0 (NOP) when not valid.
- `if_pc4`  out  32  head PC+4; 32'h0 when not valid.

## Operation
- State:
  - `pc` register.
  - Queue of DEPTH entries {instr, pc4}, with read pointer, write pointer, and count.
  - `inflight` flag: a request was issued last cycle.
  - `drop` flag: the in-flight return must be discarded.
  - Latched `pc4` of the in-flight request.
- Request rule: `imem_req` = !rst && !redirect && (count + inflight < DEPTH). `imem_addr` = `pc` (combinational from the register).
- On a request, `pc` ← `pc` + 4, modulo 2^32. The wrap from 32'hFFFF_FFFC to 0 is legal.
- Return: in the cycle after a request, `imem_rdata` is pushed with the latched pc4, unless `drop`=1 or `redirect`=1.
- Pop: when `if_valid` && !`id_stall`.
- Push and pop in the same cycle:
  - Count is unchanged.
  - If the queue was empty before the push, the pushed entry is not visible until the next cycle.
- Redirect has priority over everything. In a redirect cycle:
  - The queue is cleared (count=0, pointers=0).
  - `pc` ← {redirect_pc[31:2], 2'b00}.
  - No request is issued.
  - Any return arriving this cycle is discarded.
  - If a request is in flight, `drop` ← 1 so the return in the next cycle is discarded.
  - `if_valid` is 0 from the following cycle until new instructions arrive.
- The credit rule (count + inflight < DEPTH) guarantees no overflow. A push into a full queue is impossible. An assertion must flag it.
- `id_stall` while `if_valid`=0 has no effect.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `if_valid`=0, `if_instr`=0, `if_pc4`=0.
  - count=0, `inflight`=0, `drop`=0.
- Reset asserted mid-operation behaves like a redirect to RESET_PC and also clears `drop` and `inflight`.
- Latency:
  - Request in cycle N → data pushed at the end of N+1 → `if_valid` in N+2.
  - After reset deassertion, the first `imem_req` is in the first cycle with `rst`=0, so the first `if_valid` is two cycles later.
- Redirect in cycle R:
  - First request to the target in R+1.
  - First target instruction valid in R+3.
- Throughput: one instruction per cycle sustained when `id_stall`=0.
- With `id_stall` held, requests stop once count + inflight = DEPTH, and resume the cycle after the first pop.

## Structure
- Shared package `fetch_pkg`:
  - `NOP_INSTR` = 32'h0.
  - Default `RESET_PC`.
  - `fetch_entry_t` packed struct {instr[31:0], pc4[31:0]}.
- Sub-module `fetch_fifo` (parameter DEPTH):
  - Synchronous FIFO of `fetch_entry_t`.
  - Inputs: push, pop, flush.
  - Outputs: head, count, empty.
  - Flush takes precedence over push and pop.
- The top level holds the PC, the request/credit logic, `inflight`/`drop`, and the output muxing to NOP.

## Test plan
- Reset, RESET_PC=0, memory returns addr>>2, `id_stall`=0 → `imem_addr` 0,4,8,…; `if_valid` rises 2 cycles after reset release; `if_instr`=0,1,2,… with `if_pc4`=4,8,12, one per cycle.
- Hold `id_stall`=1 from cycle 5, DEPTH=4 → `imem_req` drops after count + inflight reaches 4; `if_instr` is held; release → requests resume the next cycle; no instruction lost or duplicated.
- `redirect`=1 with `redirect_pc`=32'h0000_0103 while a request is in flight → the in-flight return is discarded; the next `imem_addr`=32'h100; the first valid `if_pc4`=32'h104, 3 cycles after the redirect.
- Redirect and pop in the same cycle with the queue full → queue empty next cycle; `if_valid`=0, `if_instr`=0.
- `rst` pulsed for one cycle mid-stream → `if_valid`=0 the next cycle; fetch restarts at RESET_PC.
- PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; `if_pc4` values FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Queue entries pair each fetched word with the PC+4 handed to decode.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue of fetch entries.
// Flush takes precedence over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             pushEntry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ZERO_COUNT = {(PW+1){1'b0}};
  localparam logic [PW-1:0] ZERO_PTR   = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_PTR    = {{(PW-1){1'b0}}, 1'b1};

  fetch_entry_t  memR [DEPTH];
  logic [PW-1:0] rdPtrR;
  logic [PW-1:0] wrPtrR;
  logic [PW:0]   countR;
  logic          fullS;
  logic          pushOkS;
  logic          popOkS;

  // Qualify requests against occupancy and flush.
  always_comb begin
    fullS   = (countR == FULL_COUNT);
    pushOkS = push && !fullS && !flush;
    popOkS  = pop && (countR != ZERO_COUNT) && !flush;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtrR <= ZERO_PTR;
      wrPtrR <= ZERO_PTR;
      countR <= ZERO_COUNT;
    end else begin
      if (pushOkS) wrPtrR <= wrPtrR + ONE_PTR;
      if (popOkS)  rdPtrR <= rdPtrR + ONE_PTR;
      case ({pushOkS, popOkS})
        2'b10:   countR <= countR + {{PW{1'b0}}, 1'b1};
        2'b01:   countR <= countR - {{PW{1'b0}}, 1'b1};
        default: countR <= countR;
      endcase
    end
  end

  // Entry storage; stale slots are never visible because count gates the head.
  always_ff @(posedge clk) begin
    if (pushOkS) memR[wrPtrR] <= pushEntry;
  end

  assign head  = memR[rdPtrR];
  assign count = countR;
  assign empty = (countR == ZERO_COUNT);

  fetch_fifo_chk uChk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .flush(flush),
    .full (fullS)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Property checker for the prefetch queue.
// The fetch credit scheme must never push into a full queue.
module fetch_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic flush,
  input logic full
);

  // A non-flushed push while full would overwrite the head entry.
  noOverflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches,
// queues returns with PC+4 and presents one instruction per cycle to IF/ID.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pcR;
  logic [31:0]   pc4R;
  logic          inflightR;
  logic          dropR;
  logic          reqS;
  logic          pushS;
  logic          popS;
  logic          validS;
  logic [CW:0]   usedS;
  logic [CW-1:0] countS;
  logic          emptyS;
  fetch_entry_t  headS;
  fetch_entry_t  pushEntryS;
  logic          unusedRedirectLsbs;

  assign unusedRedirectLsbs = ^redirect_pc[1:0];

  // Credit check counts the in-flight return so the queue can never overflow.
  always_comb begin
    usedS      = {1'b0, countS} + {{CW{1'b0}}, inflightR};
    reqS       = !rst && !redirect && (usedS < DEPTH_W);
    pushS      = inflightR && !dropR && !redirect && !rst;
    validS     = !emptyS;
    popS       = validS && !id_stall;
    pushEntryS = '{instr: imem_rdata, pc4: pc4R};
  end

  // Output muxing: NOP and zero PC+4 whenever nothing valid is queued.
  always_comb begin
    if (validS) begin
      if_instr = headS.instr;
      if_pc4   = headS.pc4;
    end else begin
      if_instr = NOP_INSTR;
      if_pc4   = 32'h0000_0000;
    end
  end

  assign imem_req  = reqS;
  assign imem_addr = pcR;
  assign if_valid  = validS;

  // PC, in-flight tracking and discard of a return orphaned by redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcR       <= RESET_PC;
      pc4R      <= 32'h0000_0000;
      inflightR <= 1'b0;
      dropR     <= 1'b0;
    end else if (redirect) begin
      pcR       <= {redirect_pc[31:2], 2'b00};
      inflightR <= 1'b0;
      dropR     <= inflightR;
    end else begin
      inflightR <= reqS;
      dropR     <= 1'b0;
      if (reqS) begin
        pcR  <= pcR + 32'd4;
        pc4R <= pcR + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushS),
    .pushEntry(pushEntryS),
    .pop      (popS),
    .flush    (redirect),
    .head     (headS),
    .count    (countS),
    .empty    (emptyS)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a directed cycle script drives the stage
// and queues the instructions decode should accept; a monitor checks them.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  int passCnt  = 0;
  int totalCnt = 0;
  fetch_entry_t expQ[$];

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_stall   (id_stall),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc4     (if_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at addr is addr>>2, returned one cycle later.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expectRun(input logic [31:0] firstPc, input int n);
    logic [31:0] pc;
    pc = firstPc;
    for (int i = 0; i < n; i++) begin
      expQ.push_back('{instr: pc >> 2, pc4: pc + 32'd4});
      pc = pc + 32'd4;
    end
  endtask

  // Monitor: every instruction decode accepts must match the scoreboard head.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (if_valid && !id_stall && !redirect && !rst) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("FAIL sb_unexpected: got instr %h pc4 %h, expected none", if_instr, if_pc4);
      end else begin
        e = expQ.pop_front();
        check32("sb_instr", if_instr, e.instr);
        check32("sb_pc4", if_pc4, e.pc4);
      end
    end
  end

  task automatic checkCycle(input int c);
    case (c)
      0:  begin check32("c0_req", {31'd0, imem_req}, 32'd1); check32("c0_addr", imem_addr, 32'h0);
                check32("c0_valid", {31'd0, if_valid}, 32'd0); end
      1:  begin check32("c1_addr", imem_addr, 32'h4); check32("c1_valid", {31'd0, if_valid}, 32'd0); end
      2:  check32("c2_valid", {31'd0, if_valid}, 32'd1);
      5:  begin check32("c5_req", {31'd0, imem_req}, 32'd1); check32("c5_addr", imem_addr, 32'd20); end
      6:  begin check32("c6_req", {31'd0, imem_req}, 32'd1); check32("c6_addr", imem_addr, 32'd24); end
      7:  check32("c7_req_credit", {31'd0, imem_req}, 32'd0);
      8:  begin check32("c8_req_credit", {31'd0, imem_req}, 32'd0); check32("c8_hold_instr", if_instr, 32'd3);
                check32("c8_hold_pc4", if_pc4, 32'd16); check32("c8_valid", {31'd0, if_valid}, 32'd1); end
      10: check32("c10_req_first_pop", {31'd0, imem_req}, 32'd0);
      11: begin check32("c11_req_resume", {31'd0, imem_req}, 32'd1); check32("c11_addr", imem_addr, 32'd28); end
      16: check32("c16_redir_req", {31'd0, imem_req}, 32'd0);
      17: begin check32("c17_req", {31'd0, imem_req}, 32'd1); check32("c17_addr", imem_addr, 32'h100);
                check32("c17_valid", {31'd0, if_valid}, 32'd0); check32("c17_instr", if_instr, 32'h0); end
      18: check32("c18_valid", {31'd0, if_valid}, 32'd0);
      19: begin check32("c19_valid", {31'd0, if_valid}, 32'd1); check32("c19_pc4", if_pc4, 32'h104);
                check32("c19_instr", if_instr, 32'h40); end
      21: check32("c21_req_full", {31'd0, imem_req}, 32'd0);
      22: begin check32("c22_valid", {31'd0, if_valid}, 32'd1); check32("c22_instr", if_instr, 32'h40);
                check32("c22_req", {31'd0, imem_req}, 32'd0); end
      23: begin check32("c23_valid", {31'd0, if_valid}, 32'd0); check32("c23_instr", if_instr, 32'h0);
                check32("c23_pc4", if_pc4, 32'h0); check32("c23_addr", imem_addr, 32'hFFFF_FFF8); end
      24: check32("c24_addr", imem_addr, 32'hFFFF_FFFC);
      25: begin check32("c25_addr_wrap", imem_addr, 32'h0); check32("c25_pc4", if_pc4, 32'hFFFF_FFFC); end
      28: check32("c28_rst_req", {31'd0, imem_req}, 32'd0);
      29: begin check32("c29_valid", {31'd0, if_valid}, 32'd0); check32("c29_addr", imem_addr, 32'h0);
                check32("c29_req", {31'd0, imem_req}, 32'd1); end
      30: check32("c30_valid", {31'd0, if_valid}, 32'd0);
      31: check32("c31_valid", {31'd0, if_valid}, 32'd1);
      default: ;
    endcase
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_stall    = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_valid", {31'd0, if_valid}, 32'd0);
    check32("rst_instr", if_instr, 32'h0);
    check32("rst_pc4", if_pc4, 32'h0);
    for (int c = 0; c < 46; c++) begin
      @(posedge clk); #1;
      rst         = (c == 28);
      redirect    = (c == 16) || (c == 22);
      redirect_pc = (c == 16) ? 32'h0000_0103 : 32'hFFFF_FFF8;
      id_stall    = (c >= 5 && c <= 9) || (c >= 19 && c <= 21) || (c >= 40);
      if (c == 0)  expectRun(32'h0, 9);
      if (c == 22) expectRun(32'hFFFF_FFF8, 3);
      if (c == 28) expectRun(32'h0, 9);
      @(negedge clk);
      checkCycle(c);
    end
    check32("sb_drained", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
